// File: rtl/mcc_operand_dispatcher_if.sv
// Byte-stream, launch and result signals between mcc_operand_dispatcher and its neighbours.
// The slave modport is the dispatcher's view; the master modport is the surrounding system.
interface mcc_operand_dispatcher_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       start;
  logic       mode;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] c;
  logic [7:0] d;
  logic       done;
  logic       result;
  logic       res_valid;
  logic       res_data;
  logic       res_err;
  logic       res_ready;
  logic [7:0] op_count;
  logic       busy;

  modport slave (
    input  in_valid, in_data, done, result, res_ready,
    output in_ready, start, mode, a, b, c, d, res_valid, res_data, res_err, op_count, busy
  );

  modport master (
    output in_valid, in_data, done, result, res_ready,
    input  in_ready, start, mode, a, b, c, d, res_valid, res_data, res_err, op_count, busy
  );
endinterface

// File: rtl/mcc_operand_dispatcher.sv
// Assembles 5-byte frames into mode/a-d, launches multi_cycle_circuit and returns its result.
// Optional WAIT timeout abort is enabled by defining DISPATCH_TIMEOUT_EN.
module mcc_operand_dispatcher #(
  parameter int START_CYCLES = 2
`ifdef DISPATCH_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input logic                     clock,
  input logic                     reset,
  mcc_operand_dispatcher_if.slave bus
);

  typedef enum logic [1:0] {COLLECT, LAUNCH, WAIT, REPORT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic        mode_q, mode_d;
  logic [7:0]  a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic        res_data_q, res_data_d;
  logic        res_err_q, res_err_d;
  logic [7:0]  op_count_q, op_count_d;

  // One counter serves both the launch strobe length and the WAIT timeout.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= COLLECT;
      idx_q      <= 3'd0;
      cnt_q      <= 32'd0;
      mode_q     <= 1'b0;
      a_q        <= 8'd0;
      b_q        <= 8'd0;
      c_q        <= 8'd0;
      d_q        <= 8'd0;
      res_data_q <= 1'b0;
      res_err_q  <= 1'b0;
      op_count_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      d_q        <= d_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      op_count_q <= op_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    d_d        = d_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    op_count_d = op_count_q;

    case (state_q)
      COLLECT: begin
        if (bus.in_valid) begin
          idx_d = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
          case (idx_q)
            3'd0: mode_d = bus.in_data[0];
            3'd1: a_d = bus.in_data;
            3'd2: b_d = bus.in_data;
            3'd3: c_d = bus.in_data;
            3'd4: begin
              d_d     = bus.in_data;
              state_d = LAUNCH;
              cnt_d   = 32'd0;
            end
            default: idx_d = 3'd0;
          endcase
        end
      end
      LAUNCH: begin
        // An early done cuts the strobe short and reports straight away.
        if (bus.done) begin
          res_data_d = bus.result;
          res_err_d  = 1'b0;
          state_d    = REPORT;
        end else if (cnt_q == 32'(START_CYCLES - 1)) begin
          state_d = WAIT;
          cnt_d   = 32'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      WAIT: begin
        if (bus.done) begin
          res_data_d = bus.result;
          res_err_d  = 1'b0;
          state_d    = REPORT;
        end
`ifdef DISPATCH_TIMEOUT_EN
        else if (cnt_q == 32'(TIMEOUT - 1)) begin
          res_data_d = 1'b0;
          res_err_d  = 1'b1;
          state_d    = REPORT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
`endif
      end
      REPORT: begin
        if (bus.res_ready) begin
          op_count_d = op_count_q + 8'd1;
          state_d    = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  assign bus.in_ready  = (state_q == COLLECT);
  assign bus.busy      = (state_q != COLLECT);
  assign bus.start     = (state_q == LAUNCH);
  assign bus.res_valid = (state_q == REPORT);
  assign bus.mode      = mode_q;
  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.c         = c_q;
  assign bus.d         = d_q;
  assign bus.res_data  = res_data_q;
  assign bus.op_count  = op_count_q;
`ifdef DISPATCH_TIMEOUT_EN
  assign bus.res_err   = res_err_q;
`else
  assign bus.res_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mcc_operand_dispatcher.sv
// Self-checking bench for mcc_operand_dispatcher with a behavioural multi_cycle_circuit model.
// Frame contents, result timing and op_count are predicted from the frame-level rules.
module tb_mcc_operand_dispatcher;
  localparam int START_CYCLES = 2;
  localparam int TIMEOUT      = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   expOp = 0;

  logic modelDone   = 1'b0;
  logic modelResult = 1'b0;
  logic forceDone   = 1'b0;
  logic forceResult = 1'b0;
  bit   mccEnable   = 1'b1;
  logic mccResult   = 1'b0;
  int   mccDelay    = 5;

  mcc_operand_dispatcher_if bus ();

  assign bus.done   = modelDone | forceDone;
  assign bus.result = forceDone ? forceResult : modelResult;

  mcc_operand_dispatcher #(
    .START_CYCLES(START_CYCLES)
`ifdef DISPATCH_TIMEOUT_EN
    , .TIMEOUT(TIMEOUT)
`endif
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Behavioural multi_cycle_circuit: done pulses mccDelay cycles after start falls.
  initial begin : mccModel
    bit startPrev = 1'b0;
    bit pending   = 1'b0;
    int countdown = 0;
    forever begin
      @(posedge clock);
      #1;
      modelDone = 1'b0;
      if (pending) begin
        countdown--;
        if (countdown <= 0) begin
          modelDone   = 1'b1;
          modelResult = mccResult;
          pending     = 1'b0;
        end
      end
      if (startPrev && !bus.start && mccEnable) begin
        pending   = 1'b1;
        countdown = mccDelay;
      end
      startPrev = bus.start;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic sendFrame(input logic [39:0] frame);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.in_ready !== 1'b1) begin
        bad++;
        $display("[TB] FAIL in_ready_byte%0d: got=%b exp=1", i, bus.in_ready);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = frame[8*(4-i) +: 8];
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic handshake(input string tag);
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    expOp = (expOp + 1) % 256;
    total++;
    if (bus.op_count !== 8'(expOp) || bus.in_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_handshake: got op=%0d rdy=%b vld=%b busy=%b exp op=%0d rdy=1 vld=0 busy=0",
               tag, bus.op_count, bus.in_ready, bus.res_valid, bus.busy, expOp);
    end
  endtask

  // Full frame -> launch -> wait -> report, optional back-pressure and junk bytes.
  task automatic runOp(input logic [39:0] frame, input int hold, input bit junk,
                       input logic res, input int dly, input string tag);
    int n;
    logic [32:0] expOps;
    expOps    = frame[32:0];
    mccEnable = 1'b1;
    mccResult = res;
    mccDelay  = dly;
    sendFrame(frame);
    total++;
    if ({bus.mode, bus.a, bus.b, bus.c, bus.d} !== expOps) begin
      bad++;
      $display("[TB] FAIL %s_operands: got=%h exp=%h", tag, {bus.mode, bus.a, bus.b, bus.c, bus.d}, expOps);
    end
    n = 0;
    while (bus.start === 1'b1 && n < 50) begin
      if (junk) begin bus.in_valid = 1'b1; bus.in_data = 8'($urandom); end
      step();
      n++;
    end
    total++;
    if (n != START_CYCLES) begin
      bad++;
      $display("[TB] FAIL %s_start_len: got=%0d exp=%0d", tag, n, START_CYCLES);
    end
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 200) begin
      if (junk) begin bus.in_valid = 1'b1; bus.in_data = 8'($urandom); end
      step();
      n++;
    end
    total++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== res || bus.res_err !== 1'b0 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_result: got vld=%b data=%b err=%b rdy=%b exp vld=1 data=%b err=0 rdy=0",
               tag, bus.res_valid, bus.res_data, bus.res_err, bus.in_ready, res);
    end
    for (int i = 0; i < hold; i++) begin
      if (junk) begin bus.in_valid = 1'b1; bus.in_data = 8'($urandom); end
      step();
      total++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== res || bus.in_ready !== 1'b0 ||
          {bus.mode, bus.a, bus.b, bus.c, bus.d} !== expOps) begin
        bad++;
        $display("[TB] FAIL %s_hold%0d: got vld=%b data=%b rdy=%b ops=%h exp vld=1 data=%b rdy=0 ops=%h",
                 tag, i, bus.res_valid, bus.res_data, bus.in_ready,
                 {bus.mode, bus.a, bus.b, bus.c, bus.d}, res, expOps);
      end
    end
    handshake(tag);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    total++;
    if ({bus.start, bus.mode, bus.a, bus.b, bus.c, bus.d, bus.res_valid, bus.res_data,
         bus.res_err, bus.op_count, bus.busy} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got nonzero start=%b mode=%b a=%h op=%h busy=%b exp all 0",
               bus.start, bus.mode, bus.a, bus.op_count, bus.busy);
    end
    reset = 1'b1;
    step();
    total++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_release: got rdy=%b busy=%b exp rdy=1 busy=0", bus.in_ready, bus.busy);
    end
    expOp = 0;
  endtask

  task automatic test_first_frame();
    runOp(40'h00_01_02_FF_FE, 0, 1'b0, 1'b1, 5, "first");
  endtask

  task automatic test_backpressure();
    runOp(40'h01_FE_01_01_04, 10, 1'b0, 1'($urandom), 5, "bp");
  endtask

  task automatic test_junk_bytes();
    runOp({8'h00, 32'($urandom)}, 3, 1'b1, 1'($urandom), 4, "junk");
    runOp(40'h00_01_FF_FF_FF, 0, 1'b0, 1'($urandom), 2, "after_junk");
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = (i == 1) ? 8'hFF : 8'h01;
      step();
    end
    bus.in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    total++;
    if ({bus.start, bus.mode, bus.a, bus.b, bus.c, bus.d, bus.res_valid, bus.res_data,
         bus.res_err, bus.op_count, bus.busy} !== '0) begin
      bad++;
      $display("[TB] FAIL midreset_outputs: got mode=%b a=%h b=%h op=%h exp all 0",
               bus.mode, bus.a, bus.b, bus.op_count);
    end
    step();
    reset = 1'b1;
    step();
    expOp = 0;
    runOp(40'h01_FF_01_01_FF, 0, 1'b0, 1'($urandom), 3, "postreset");
  endtask

  task automatic test_done_ignored_in_collect();
    forceResult = 1'b1;
    forceDone   = 1'b1;
    step();
    forceDone = 1'b0;
    total++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.op_count !== 8'(expOp)) begin
      bad++;
      $display("[TB] FAIL collect_done: got vld=%b busy=%b op=%0d exp vld=0 busy=0 op=%0d",
               bus.res_valid, bus.busy, bus.op_count, expOp);
    end
  endtask

  task automatic test_done_in_launch();
    logic r;
    r = 1'($urandom);
    mccEnable = 1'b0;
    sendFrame({8'h01, 32'($urandom)});
    forceResult = r;
    forceDone   = 1'b1;
    step();
    forceDone = 1'b0;
    total++;
    if (bus.start !== 1'b0 || bus.res_valid !== 1'b1 || bus.res_data !== r || bus.res_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL launch_done: got start=%b vld=%b data=%b err=%b exp start=0 vld=1 data=%b err=0",
               bus.start, bus.res_valid, bus.res_data, bus.res_err, r);
    end
    handshake("launch_done");
    mccEnable = 1'b1;
  endtask

  task automatic test_wait_behaviour();
    int n;
    mccEnable = 1'b0;
    sendFrame({8'h00, 32'($urandom)});
    n = 0;
    while (bus.start === 1'b1 && n < 50) begin step(); n++; end
`ifdef DISPATCH_TIMEOUT_EN
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 200) begin step(); n++; end
    total++;
    if (n != TIMEOUT || bus.res_err !== 1'b1 || bus.res_data !== 1'b0) begin
      bad++;
      $display("[TB] FAIL timeout: got cycles=%0d err=%b data=%b exp cycles=%0d err=1 data=0",
               n, bus.res_err, bus.res_data, TIMEOUT);
    end
    handshake("timeout");
    sendFrame({8'h01, 32'($urandom)});
    n = 0;
    while (bus.start === 1'b1 && n < 50) begin step(); n++; end
    repeat (TIMEOUT - 1) step();
    forceResult = 1'b1;
    forceDone   = 1'b1;
    step();
    forceDone = 1'b0;
    total++;
    if (bus.res_valid !== 1'b1 || bus.res_err !== 1'b0 || bus.res_data !== 1'b1) begin
      bad++;
      $display("[TB] FAIL timeout_tie: got vld=%b err=%b data=%b exp vld=1 err=0 data=1",
               bus.res_valid, bus.res_err, bus.res_data);
    end
    handshake("timeout_tie");
`else
    repeat (100) step();
    total++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL wait_hold: got vld=%b busy=%b exp vld=0 busy=1", bus.res_valid, bus.busy);
    end
    forceResult = 1'b1;
    forceDone   = 1'b1;
    step();
    forceDone = 1'b0;
    total++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 1'b1 || bus.res_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL wait_late_done: got vld=%b data=%b err=%b exp vld=1 data=1 err=0",
               bus.res_valid, bus.res_data, bus.res_err);
    end
    handshake("wait_late");
`endif
    mccEnable = 1'b1;
  endtask

  task automatic test_op_count_wrap();
    bit sawWrap;
    sawWrap = 1'b0;
    for (int i = 0; i < 256; i++) begin
      runOp({7'($urandom), 33'({$urandom, $urandom})}, 0, 1'b0, 1'($urandom),
            int'($urandom_range(1, 3)), "loop");
      if (expOp == 0) sawWrap = 1'b1;
    end
    total++;
    if (!sawWrap || bus.op_count !== 8'(expOp)) begin
      bad++;
      $display("[TB] FAIL op_wrap: got op=%0d wrapped=%b exp op=%0d wrapped=1", bus.op_count, sawWrap, expOp);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.res_ready = 1'b0;
    test_reset();
    test_first_frame();
    test_backpressure();
    test_junk_bytes();
    test_reset_mid_frame();
    test_done_ignored_in_collect();
    test_done_in_launch();
    test_wait_behaviour();
    test_op_count_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mcc_operand_dispatcher.md
# mcc_operand_dispatcher

Upstream feeder for `multi_cycle_circuit`. It accepts a byte stream over a valid/ready handshake and assembles each 5-byte frame into `mode` plus operands `a`–`d`. It then drives a `start` pulse, waits for `done`, captures `result`, and returns it over a second valid/ready handshake. It replaces hand-driven `start`/operand stimulus with a self-timed, back-pressured front end.

## Interface
- `START_CYCLES`, default 2: cycles `start` is held high per launch; legal range ≥1.
- `TIMEOUT`, default 64: maximum WAIT cycles before abort; legal range ≥1. Used only with `DISPATCH_TIMEOUT_EN`.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream byte valid.
- `in_data`  in  8  upstream byte.
- `in_ready`  out  1  dispatcher can accept a byte.
- `start`  out  1  launch strobe to `multi_cycle_circuit`.
- `mode`  out  1  operation select, taken from header bit 0.
- `a`, `b`, `c`, `d`  out  8 each  operands.
- `done`  in  1  completion from `multi_cycle_circuit`.
- `result`  in  1  result from `multi_cycle_circuit`.
- `res_valid`  out  1  result available.
- `res_data`  out  1  captured `result`.
- `res_err`  out  1  result is a timeout abort.
- `res_ready`  in  1  downstream accepts the result.
- `op_count`  out  8  completed result handshakes; wraps modulo 256.
- `busy`  out  1  high in every state except COLLECT.

## Operation
- States: COLLECT, LAUNCH, WAIT, REPORT. Reset state is COLLECT.
- **COLLECT:** `in_ready`=1. A byte is accepted on the edge where `in_valid && in_ready`. A 3-bit index selects its destination:
  - index 0 = header; bit 0 → `mode`; bits [7:1] ignored.
  - index 1..4 = `a`, `b`, `c`, `d`.
  - Accepting index 4 resets the index to 0 and moves to LAUNCH.
- **LAUNCH:** `start`=1 for exactly `START_CYCLES` cycles, counted by the launch counter. When the counter expires, move to WAIT.
- **WAIT:** `start`=0. On `done`=1, capture `result` into `res_data`, set `res_err`=0, move to REPORT.
- `done` is also honoured during LAUNCH: capture the result, go straight to REPORT, and drop `start` on that edge.
- **REPORT:** `res_valid`=1, `res_data`/`res_err` held stable. On `res_valid && res_ready`: increment `op_count` (255→0) and return to COLLECT.
- `in_ready`=0 in LAUNCH, WAIT and REPORT. `in_valid` is ignored there, with no data loss, because upstream must hold.
- `mode` and `a`–`d` are registered. They stay stable from the last COLLECT edge until the next frame overwrites them.
- A `done` outside LAUNCH/WAIT is ignored.

## Timing
- Reset (asynchronous, `reset`=0): state=COLLECT, index=0, and all of the following are 0: `start`, `mode`, `a`–`d`, `res_valid`, `res_data`, `res_err`, `op_count`, `busy`. `in_ready`=1 once `reset` is high.
- Reset mid-frame or mid-operation aborts immediately. Partial frames and pending results are discarded, and no handshake completes.
- Accepting the 5th byte on edge N gives `start`=1 from edge N through edge N+`START_CYCLES`.
- `done` sampled high on edge M gives `res_valid`=1 after edge M.
- Minimum frame-to-frame throughput: 5 + `START_CYCLES` + mcc latency + 1 (REPORT) cycles.
- Leaving REPORT on edge K gives `in_ready`=1 after edge K. Back-to-back bytes at one per cycle are supported within a frame.

## Configuration
- Macro: `DISPATCH_TIMEOUT_EN`.
- **Defined:** an 8-bit-or-wider WAIT counter clears on entry to WAIT.
  - If it reaches `TIMEOUT` with no `done`, go to REPORT with `res_err`=1 and `res_data`=0.
  - A `done` on the same edge as expiry wins: normal result, `res_err`=0.
- **Undefined:** WAIT persists until `done` or reset. `res_err` is tied to 0 and no counter is built.

## Test plan
- Reset then frame 00,01,02,FF,FE; mcc model asserts `done` with `result`=1 five cycles after `start` falls.
  - Required: `mode`=0, `a`=01, `b`=02, `c`=FF, `d`=FE; `start` high exactly 2 cycles; `res_valid`=1, `res_data`=1, `res_err`=0; `op_count`=1 after `res_ready`.
- Frame 01,FE,01,01,04 with `res_ready` held low 10 cycles.
  - Required: `mode`=1; `res_valid` and `res_data` stable throughout; `in_ready`=0 until the handshake; then `in_ready`=1.
- Bytes offered continuously during WAIT/REPORT.
  - Required: none accepted. Next frame 00,01,FF,FF,FF loads `a`=01, `b`=`c`=`d`=FF exactly.
- `reset` pulsed low after 3 bytes of frame 01,FF,01,01,FF.
  - Required: all outputs 0 immediately. A fresh full frame afterwards gives `mode`=1, `a`=FF, `d`=FF with no leftover bytes.
- With `DISPATCH_TIMEOUT_EN`, `TIMEOUT`=16, mcc never asserts `done`.
  - Required: `res_valid`=1, `res_err`=1, `res_data`=0, 16 cycles after entering WAIT.
  - `done` coincident with expiry gives `res_err`=0.
- 256 completed operations.
  - Required: `op_count` wraps FF→00.
